// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: buffers {pc, instr} pairs and shows the oldest entry to decode.
// Latency: an entry enqueued at edge N appears on out_* after edge N (1 cycle from empty, no bypass).
// Backpressure: in_ready drops while full (no pass-through on a same-cycle dequeue); flush/rst empty the queue.
module inst_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } q_state_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    q_state_t         state;
    q_state_t         state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             enq;
    logic             deq;

    // Occupancy class is kept as a registered state so the handshake outputs come straight from flops.
    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);

    always_comb begin
        enq       = in_valid & in_ready & ~flush & ~rst;
        deq       = out_valid & out_ready & ~flush & ~rst;
        count_nxt = count;
        if (rst || flush) begin
            count_nxt = '0;
        end else if (enq && !deq) begin
            count_nxt = count + CNT_W'(1);
        end else if (deq && !enq) begin
            count_nxt = count - CNT_W'(1);
        end
        state_nxt = S_PARTIAL;
        if (count_nxt == '0) begin
            state_nxt = S_EMPTY;
        end else if (count_nxt == CNT_W'(DEPTH)) begin
            state_nxt = S_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_EMPTY;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // Storage is never cleared; the masked outputs hide stale contents.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{pc: in_pc, dat: in_data};
        end
    end

    always_comb begin
        head     = mem[rd_ptr];
        out_pc   = '0;
        out_data = '0;
        if (out_valid) begin
            out_pc   = head.pc;
            out_data = head.dat;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed and randomized checks of inst_queue against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_pc = '0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] mq[$];

    inst_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
        .out_data(out_data), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, then land on the next negedge.
    task automatic step(input logic r, input logic fl, input logic iv, input logic ordy,
                        input logic [15:0] pc, input logic [31:0] d);
        bit can_enq, can_deq;
        rst = r; flush = fl; in_valid = iv; out_ready = ordy; in_pc = pc; in_data = d;
        can_enq = iv && (mq.size() < DEPTH) && !fl && !r;
        can_deq = ordy && (mq.size() > 0) && !fl && !r;
        @(posedge clk);
        if (r || fl) begin
            mq.delete();
        end else begin
            if (can_deq) void'(mq.pop_front());
            if (can_enq) mq.push_back({pc, d});
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        logic [47:0] h;
        h = (mq.size() > 0) ? mq[0] : 48'h0;
        chk({tag, ".count"},     64'(count),     64'(mq.size()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(h[47:32]));
        chk({tag, ".out_data"},  64'(out_data),  64'(h[31:0]));
    endtask

    initial begin
        @(negedge clk);

        step(1, 0, 0, 0, 16'h0, 32'h0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_pc", 64'(out_pc), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        step(0, 0, 1, 0, 16'h0000, 32'h20080005);
        chk("first.out_valid", 64'(out_valid), 64'd1);
        chk("first.out_pc", 64'(out_pc), 64'h0);
        chk("first.out_data", 64'(out_data), 64'h20080005);
        chk("first.count", 64'(count), 64'd1);
        step(0, 0, 0, 1, 16'h0, 32'h0);
        chk_model("drain1");

        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'(i * 4), $urandom);
        chk("fill.count", 64'(count), 64'd4);
        chk("fill.in_ready", 64'(in_ready), 64'd0);
        step(0, 0, 1, 0, 16'h0010, $urandom);
        chk("full_ignore.count", 64'(count), 64'd4);
        chk_model("full_ignore");
        for (int i = 0; i < 4; i++) begin
            chk("drain.out_pc", 64'(out_pc), 64'(i * 4));
            chk_model("drain");
            step(0, 0, 0, 1, 16'h0, 32'h0);
        end
        chk("drained.out_valid", 64'(out_valid), 64'd0);
        chk("drained.out_data", 64'(out_data), 64'd0);

        step(0, 0, 1, 1, 16'h0000, $urandom);
        for (int i = 1; i < 10; i++) begin
            chk("stream.out_pc", 64'(out_pc), 64'((i - 1) * 4));
            chk("stream.count", 64'(count), 64'd1);
            chk_model("stream");
            step(0, 0, 1, 1, 16'(i * 4), $urandom);
        end
        chk("stream.last_pc", 64'(out_pc), 64'h24);
        step(0, 0, 0, 1, 16'h0, 32'h0);
        chk_model("stream_end");

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'(16'h30 + i * 4), $urandom);
        step(0, 1, 1, 1, 16'h0040, 32'hDEADBEEF);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        step(0, 0, 0, 1, 16'h0, 32'h0);
        chk("flush.no40", 64'(out_valid), 64'd0);

        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'(16'h80 + i * 4), $urandom);
        step(0, 0, 1, 1, 16'h0099, 32'h99999999);
        chk("fulldeq.count", 64'(count), 64'd3);
        chk("fulldeq.in_ready", 64'(in_ready), 64'd1);
        chk("fulldeq.out_pc", 64'(out_pc), 64'h84);
        for (int i = 0; i < 3; i++) begin
            chk_model("fulldeq_drain");
            step(0, 0, 0, 1, 16'h0, 32'h0);
        end
        chk_model("fulldeq_empty");

        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 16'(16'hA0 + i * 4), $urandom);
        step(1, 0, 1, 1, 16'h00B0, $urandom);
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.out_pc", 64'(out_pc), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 50),
                 16'($urandom), $urandom);
            chk_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
